// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall/flush control,
// E-stage forwarding selects, multi-cycle execute hold and perf counters.
//
// state   | meaning
// RUN     | normal issue; load-use, control-flush and mul-start handling
// MC_WAIT | pipeline held while the multi-cycle unit runs
module pipeline_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PCSrcE,
    input  logic             MulStartE,
    input  logic             MulDoneE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             McBusy,
    output logic             McError,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCycles
);

    localparam int TW = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MC_TIMEOUT - 1);

    typedef enum logic [0:0] {RUN, MC_WAIT} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_last;
    logic          lw_stall;

    assign tmo_last = (tmo_cnt == TMO_LAST);
    assign lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        state_nxt = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        McBusy    = (state == MC_WAIT);

        // M result is newer than W, so it wins on a double match
        if (RegWriteM && (RdM == Rs1E) && (Rs1E != 5'd0))      ForwardAE = 2'b10;
        else if (RegWriteW && (RdW == Rs1E) && (Rs1E != 5'd0)) ForwardAE = 2'b01;
        if (RegWriteM && (RdM == Rs2E) && (Rs2E != 5'd0))      ForwardBE = 2'b10;
        else if (RegWriteW && (RdW == Rs2E) && (Rs2E != 5'd0)) ForwardBE = 2'b01;

        case (state)
            RUN: begin
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                end else if (MulStartE && !MulDoneE) begin
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    FlushM    = 1'b1;
                    state_nxt = MC_WAIT;
                end else if (lw_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            MC_WAIT: begin
                if (MulDoneE || tmo_last) begin
                    state_nxt = RUN;
                end else begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    FlushM = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase

        if (!reset) begin
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushM    = 1'b0;
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
            McBusy    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            tmo_cnt     <= '0;
            McError     <= 1'b0;
            StallCycles <= '0;
            FlushCycles <= '0;
        end else begin
            state <= state_nxt;
            if ((state == MC_WAIT) && (state_nxt == MC_WAIT))
                tmo_cnt <= tmo_cnt + TW'(1);
            else
                tmo_cnt <= '0;
            if ((state == MC_WAIT) && !MulDoneE && tmo_last)
                McError <= 1'b1;
            if (StallD && !(&StallCycles))
                StallCycles <= StallCycles + CNT_W'(1);
            if (FlushE && !(&FlushCycles))
                FlushCycles <= FlushCycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MC_TIMEOUT=8, CNT_W=4).
module tb_pipeline_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, MulStartE, MulDoneE;
    logic       StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       McBusy, McError;
    logic [3:0] StallCycles, FlushCycles;
    logic [5:0] ctl;

    int vec_cnt = 0;
    int err_cnt = 0;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    pipeline_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
        .MulStartE(MulStartE), .MulDoneE(MulDoneE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .McBusy(McBusy), .McError(McError),
        .StallCycles(StallCycles), .FlushCycles(FlushCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0;
        ResultSrcE = 2'b00; PCSrcE = 0; MulStartE = 0; MulDoneE = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        ResultSrcE = 2'b01; RdE = 7; Rs1D = 7;
        Rs1E = 5; RdM = 5; RegWriteM = 1; MulStartE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin
            err_cnt++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000000);
        end
        vec_cnt++;
        if (ForwardAE !== 2'b00 || McBusy !== 1'b0) begin
            err_cnt++; $display("FAIL reset_fwd_busy: got fa=%b busy=%b expected fa=00 busy=0", ForwardAE, McBusy);
        end
        cyc();
        vec_cnt++;
        if (StallCycles !== 4'd0 || FlushCycles !== 4'd0 || McError !== 1'b0) begin
            err_cnt++; $display("FAIL reset_state: got sc=%0d fc=%0d err=%b expected 0 0 0", StallCycles, FlushCycles, McError);
        end
        idle();
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000 || McBusy !== 1'b0) begin
            err_cnt++; $display("FAIL reset_release: got ctl=%b busy=%b expected 000000 0", ctl, McBusy);
        end
    endtask

    task automatic test_forwarding();
        idle();
        Rs1E = 5; Rs2E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1;
        vec_cnt++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b10) begin
            err_cnt++; $display("FAIL fwd_m_wins: got %b %b expected 10 10", ForwardAE, ForwardBE);
        end
        RegWriteM = 0;
        #1;
        vec_cnt++;
        if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
            err_cnt++; $display("FAIL fwd_w: got %b %b expected 01 01", ForwardAE, ForwardBE);
        end
        Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        #1;
        vec_cnt++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            err_cnt++; $display("FAIL fwd_x0: got %b %b expected 00 00", ForwardAE, ForwardBE);
        end
        Rs1E = 3; Rs2E = 9; RdM = 3; RdW = 9; RegWriteM = 1; RegWriteW = 1;
        #1;
        vec_cnt++;
        if (ForwardAE !== 2'b10 || ForwardBE !== 2'b01) begin
            err_cnt++; $display("FAIL fwd_split: got %b %b expected 10 01", ForwardAE, ForwardBE);
        end
        RegWriteW = 0;
        #1;
        vec_cnt++;
        if (ForwardBE !== 2'b00) begin
            err_cnt++; $display("FAIL fwd_b_none: got %b expected 00", ForwardBE);
        end
        idle();
    endtask

    task automatic test_load_use();
        do_reset();
        ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
        #1;
        vec_cnt++;
        if (ctl !== 6'b110010) begin
            err_cnt++; $display("FAIL lw_stall: got %b expected %b", ctl, 6'b110010);
        end
        cyc();
        ResultSrcE = 2'b00; RdE = 0; Rs2D = 0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin
            err_cnt++; $display("FAIL lw_one_bubble: got %b expected %b", ctl, 6'b000000);
        end
        vec_cnt++;
        if (StallCycles !== 4'd1 || FlushCycles !== 4'd1) begin
            err_cnt++; $display("FAIL lw_counters: got sc=%0d fc=%0d expected 1 1", StallCycles, FlushCycles);
        end
        ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin
            err_cnt++; $display("FAIL lw_rd_x0: got %b expected %b", ctl, 6'b000000);
        end
        RdE = 7; Rs2D = 7; PCSrcE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000110) begin
            err_cnt++; $display("FAIL lw_vs_branch: got %b expected %b", ctl, 6'b000110);
        end
        cyc();
        idle();
        #1;
        vec_cnt++;
        if (StallCycles !== 4'd1 || FlushCycles !== 4'd2) begin
            err_cnt++; $display("FAIL branch_counters: got sc=%0d fc=%0d expected 1 2", StallCycles, FlushCycles);
        end
    endtask

    task automatic test_multicycle();
        do_reset();
        MulStartE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b111001 || McBusy !== 1'b0) begin
            err_cnt++; $display("FAIL mc_start: got ctl=%b busy=%b expected 111001 0", ctl, McBusy);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            PCSrcE = (k == 2);
            ResultSrcE = 2'b01; RdE = 4; Rs1D = 4;
            #1;
            vec_cnt++;
            if (ctl !== 6'b111001 || McBusy !== 1'b1) begin
                err_cnt++; $display("FAIL mc_wait_%0d: got ctl=%b busy=%b expected 111001 1", k, ctl, McBusy);
            end
        end
        cyc();
        idle();
        MulStartE = 1; MulDoneE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000 || McBusy !== 1'b1) begin
            err_cnt++; $display("FAIL mc_done: got ctl=%b busy=%b expected 000000 1", ctl, McBusy);
        end
        cyc();
        idle();
        #1;
        vec_cnt++;
        if (McBusy !== 1'b0 || StallCycles !== 4'd4 || FlushCycles !== 4'd0 || McError !== 1'b0) begin
            err_cnt++; $display("FAIL mc_after: got busy=%b sc=%0d fc=%0d err=%b expected 0 4 0 0", McBusy, StallCycles, FlushCycles, McError);
        end
        MulStartE = 1; MulDoneE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin
            err_cnt++; $display("FAIL mc_single: got %b expected %b", ctl, 6'b000000);
        end
        cyc();
        idle();
        #1;
        vec_cnt++;
        if (McBusy !== 1'b0 || StallCycles !== 4'd4) begin
            err_cnt++; $display("FAIL mc_single_after: got busy=%b sc=%0d expected 0 4", McBusy, StallCycles);
        end
        MulStartE = 1; PCSrcE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000110) begin
            err_cnt++; $display("FAIL mc_vs_branch: got %b expected %b", ctl, 6'b000110);
        end
        cyc();
        idle();
        #1;
        vec_cnt++;
        if (McBusy !== 1'b0) begin
            err_cnt++; $display("FAIL mc_vs_branch_state: got busy=%b expected 0", McBusy);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        MulStartE = 1;
        #1;
        vec_cnt++;
        if (StallD !== 1'b1) begin
            err_cnt++; $display("FAIL tmo_start: got %b expected 1", StallD);
        end
        for (int k = 1; k <= 7; k++) begin
            cyc();
            MulStartE = 0;
            #1;
            vec_cnt++;
            if (ctl !== 6'b111001 || McBusy !== 1'b1 || McError !== 1'b0) begin
                err_cnt++; $display("FAIL tmo_wait_%0d: got ctl=%b busy=%b err=%b expected 111001 1 0", k, ctl, McBusy, McError);
            end
        end
        cyc();
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000 || McBusy !== 1'b1 || McError !== 1'b0) begin
            err_cnt++; $display("FAIL tmo_release: got ctl=%b busy=%b err=%b expected 000000 1 0", ctl, McBusy, McError);
        end
        cyc();
        #1;
        vec_cnt++;
        if (McError !== 1'b1 || McBusy !== 1'b0 || StallCycles !== 4'd8) begin
            err_cnt++; $display("FAIL tmo_after: got err=%b busy=%b sc=%0d expected 1 0 8", McError, McBusy, StallCycles);
        end
        MulStartE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b111001) begin
            err_cnt++; $display("FAIL tmo_restart: got %b expected %b", ctl, 6'b111001);
        end
        cyc();
        MulStartE = 0;
        cyc();
        MulDoneE = 1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000 || McBusy !== 1'b1) begin
            err_cnt++; $display("FAIL tmo_restart_done: got ctl=%b busy=%b expected 000000 1", ctl, McBusy);
        end
        cyc();
        MulDoneE = 0;
        #1;
        vec_cnt++;
        if (McError !== 1'b1 || McBusy !== 1'b0 || StallCycles !== 4'd10) begin
            err_cnt++; $display("FAIL tmo_sticky: got err=%b busy=%b sc=%0d expected 1 0 10", McError, McBusy, StallCycles);
        end
    endtask

    // Entered with McError=1 and nonzero counters left by test_timeout
    task automatic test_reset_mid_wait();
        idle();
        MulStartE = 1;
        cyc();
        MulStartE = 0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000 || McBusy !== 1'b0 || McError !== 1'b1) begin
            err_cnt++; $display("FAIL rstwait_now: got ctl=%b busy=%b err=%b expected 000000 0 1", ctl, McBusy, McError);
        end
        cyc();
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (McBusy !== 1'b0 || ctl !== 6'b000000 || McError !== 1'b0 ||
            StallCycles !== 4'd0 || FlushCycles !== 4'd0) begin
            err_cnt++; $display("FAIL rstwait_after: got busy=%b ctl=%b err=%b sc=%0d fc=%0d expected 0 000000 0 0 0",
                                McBusy, ctl, McError, StallCycles, FlushCycles);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ResultSrcE = 2'b01; RdE = 12; Rs1D = 12;
        for (int k = 0; k < 14; k++) cyc();
        #1;
        vec_cnt++;
        if (StallCycles !== 4'd14 || FlushCycles !== 4'd14) begin
            err_cnt++; $display("FAIL sat_pre: got sc=%0d fc=%0d expected 14 14", StallCycles, FlushCycles);
        end
        for (int k = 0; k < 6; k++) cyc();
        #1;
        vec_cnt++;
        if (StallCycles !== 4'd15 || FlushCycles !== 4'd15) begin
            err_cnt++; $display("FAIL sat_hold: got sc=%0d fc=%0d expected 15 15", StallCycles, FlushCycles);
        end
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        cyc();
        test_reset();
        test_forwarding();
        test_load_use();
        test_multicycle();
        test_timeout();
        test_reset_mid_wait();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
